// File: rtl/ex_alu_exec.sv
// ex_alu_exec: execute stage with ALU, branch/JAL resolution, flush/redirect and a 1-bit-per-cycle shifter
module ex_alu_exec #(
  parameter int XLEN = 32,
  parameter logic [3:0] ALU_OP_ADD = 4'd0,
  parameter logic [3:0] ALU_OP_SUB = 4'd1,
  parameter logic [3:0] ALU_OP_AND = 4'd2,
  parameter logic [3:0] ALU_OP_OR = 4'd3,
  parameter logic [3:0] ALU_OP_XOR = 4'd4,
  parameter logic [3:0] ALU_OP_LT = 4'd5,
  parameter logic [3:0] ALU_OP_JUMP = 4'd6,
  parameter logic [3:0] ALU_OP_SHIFT_LEFT = 4'd7,
  parameter logic [3:0] ALU_OP_SHIFT_RIGHT = 4'd8,
  parameter logic [3:0] ALU_OP_NOPE = 4'd9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [3:0]      ALU_op,
  input  logic [XLEN-1:0] id_operand_a,
  input  logic [XLEN-1:0] id_operand_b,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_cond_branch,
  input  logic [4:0]      id_rd,
  input  logic            id_reg_write,
  output logic            ex_stall,
  output logic            EX_flush,
  output logic            ex_redirect_valid,
  output logic [XLEN-1:0] ex_redirect_pc,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_result,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d, sh_rd_q, sh_rd_d, ex_rd_q, ex_rd_d;
  logic [XLEN-1:0] sh_q, sh_d, sh_next, ex_result_q, ex_result_d, redir_pc_q, redir_pc_d, alu_res;
  logic left_q, left_d, sh_rw_q, sh_rw_d, ex_valid_q, ex_valid_d, ex_reg_write_q, ex_reg_write_d;
  logic redir_valid_q, redir_valid_d;
  logic [1:0] flush_q, flush_d;
  logic live, lt, eq, is_shift, taken, redir;
  assign ex_stall = state_q == SHIFT;
  assign EX_flush = flush_q != 2'd0;
  assign ex_redirect_valid = redir_valid_q;
  assign ex_redirect_pc = redir_pc_q;
  assign ex_valid = ex_valid_q;
  assign ex_result = ex_result_q;
  assign ex_rd = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign live = id_valid && !ex_stall && !EX_flush;
  assign lt = $signed(id_operand_a) < $signed(id_operand_b);
  assign eq = id_operand_a == id_operand_b;
  assign is_shift = ALU_op == ALU_OP_SHIFT_LEFT || ALU_op == ALU_OP_SHIFT_RIGHT;
  assign taken = id_cond_branch && ((ALU_op == ALU_OP_LT && lt) || (ALU_op == ALU_OP_SUB && eq));
  assign redir = live && (taken || ALU_op == ALU_OP_JUMP);
  assign sh_next = left_q ? sh_q << 1 : sh_q >> 1;
  assign alu_res = ALU_op == ALU_OP_ADD ? id_operand_a + id_operand_b :
                   ALU_op == ALU_OP_SUB ? id_operand_a - id_operand_b :
                   ALU_op == ALU_OP_AND ? id_operand_a & id_operand_b :
                   ALU_op == ALU_OP_OR ? id_operand_a | id_operand_b :
                   ALU_op == ALU_OP_XOR ? id_operand_a ^ id_operand_b :
                   ALU_op == ALU_OP_LT ? {{(XLEN-1){1'b0}}, lt} :
                   ALU_op == ALU_OP_JUMP ? id_pc + XLEN'(4) :
                   is_shift ? id_operand_a : id_operand_a + id_operand_b;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    left_d = left_q;
    sh_rd_d = sh_rd_q;
    sh_rw_d = sh_rw_q;
    ex_valid_d = 1'b0;
    ex_result_d = ex_result_q;
    ex_rd_d = ex_rd_q;
    ex_reg_write_d = 1'b0;
    redir_valid_d = redir;
    redir_pc_d = redir ? id_pc + id_imm : redir_pc_q;
    flush_d = redir ? 2'd2 : flush_q == 2'd0 ? 2'd0 : flush_q - 2'd1;
    if (state_q == SHIFT) begin
      sh_d = sh_next;
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        state_d = IDLE;
        ex_valid_d = 1'b1;
        ex_result_d = sh_next;
        ex_rd_d = sh_rd_q;
        ex_reg_write_d = sh_rw_q;
      end
    end else if (live && ALU_op != ALU_OP_NOPE) begin
      if (is_shift && id_operand_b[4:0] != 5'd0) begin
        state_d = SHIFT;
        cnt_d = id_operand_b[4:0];
        sh_d = id_operand_a;
        left_d = ALU_op == ALU_OP_SHIFT_LEFT;
        sh_rd_d = id_rd;
        sh_rw_d = id_reg_write;
      end else begin
        ex_valid_d = 1'b1;
        ex_result_d = alu_res;
        ex_rd_d = id_rd;
        ex_reg_write_d = id_reg_write && !id_cond_branch;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      left_q <= 1'b0;
      sh_rd_q <= '0;
      sh_rw_q <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_result_q <= '0;
      ex_rd_q <= '0;
      ex_reg_write_q <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      left_q <= left_d;
      sh_rd_q <= sh_rd_d;
      sh_rw_q <= sh_rw_d;
      ex_valid_q <= ex_valid_d;
      ex_result_q <= ex_result_d;
      ex_rd_q <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q <= redir_pc_d;
      flush_q <= flush_d;
    end
  end
endmodule
